// File: rtl/bsg_gray_ptr_to_binary_rx_pkg.sv
// Shared defaults for Gray pointer receivers.
// Width and synchronizer depth used when a receiver is not overridden.
package bsg_gray_ptr_to_binary_rx_pkg;

    localparam int default_width_lp       = 32;
    localparam int default_sync_stages_lp = 2;

endpackage

// File: rtl/bsg_gray_to_binary.sv
// Combinational Gray-to-binary decoder.
// Running XOR from the MSB down; reusable by any pointer receiver.
module bsg_gray_to_binary #(
    parameter int width_p = 32
) (
    input  logic [width_p-1:0] gray_i,
    output logic [width_p-1:0] binary_o
);

    logic acc;

    always_comb begin
        acc      = 1'b0;
        binary_o = '0;
        for (int i = width_p - 1; i >= 0; i--) begin
            acc         = acc ^ gray_i[i];
            binary_o[i] = acc;
        end
    end

endmodule

// File: rtl/bsg_gray_ptr_to_binary_rx.sv
// Consumer side of a Gray pointer crossing: sync, decode, report advance.
// Flags any sample-to-sample change touching more than one Gray bit.
module bsg_gray_ptr_to_binary_rx
    import bsg_gray_ptr_to_binary_rx_pkg::*;
#(
    parameter int width_p       = default_width_lp,
    parameter int sync_stages_p = default_sync_stages_lp
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] gray_i,
    input  logic               clear_err_i,
    output logic [width_p-1:0] binary_o,
    output logic [width_p-1:0] delta_o,
    output logic               v_o,
    output logic               err_o
);

    logic [width_p-1:0] sync_r [sync_stages_p];
    logic [width_p-1:0] g_s;
    logic [width_p-1:0] g_prev_r;
    logic [width_p-1:0] g_diff;
    logic [width_p-1:0] b;
    logic               multi_bit;

    assign g_s    = sync_r[sync_stages_p-1];
    assign g_diff = g_s ^ g_prev_r;

    // Clearing the lowest set bit leaves something only if >1 bit was set.
    assign multi_bit = |(g_diff & (g_diff - width_p'(1)));

    bsg_gray_to_binary #(
        .width_p(width_p)
    ) u_g2b (
        .gray_i  (g_s),
        .binary_o(b)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < sync_stages_p; i++) begin
                sync_r[i] <= '0;
            end
            g_prev_r <= '0;
            binary_o <= '0;
            delta_o  <= '0;
            v_o      <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            sync_r[0] <= gray_i;
            for (int i = 1; i < sync_stages_p; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
            g_prev_r <= g_s;
            binary_o <= b;
            delta_o  <= b - binary_o;
            v_o      <= (b != binary_o);
            // A fresh error outranks a simultaneous clear.
            if (multi_bit) begin
                err_o <= 1'b1;
            end else if (clear_err_i) begin
                err_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bsg_gray_ptr_to_binary_rx.sv
// Bench for the Gray pointer receiver at 2 and 3 sync stages.
// Reference model works from input history and arithmetic decode.
module tb_bsg_gray_ptr_to_binary_rx;

    logic        clk;
    logic        reset_n;
    logic [31:0] gray;
    logic        clear_err;

    logic [31:0] bin2, delta2, bin3, delta3;
    logic        v2, err2, v3, err3;

    int checks = 0;
    int errors = 0;

    bsg_gray_ptr_to_binary_rx #(
        .width_p(32),
        .sync_stages_p(2)
    ) u_dut2 (
        .clk_i      (clk),
        .reset_n_i  (reset_n),
        .gray_i     (gray),
        .clear_err_i(clear_err),
        .binary_o   (bin2),
        .delta_o    (delta2),
        .v_o        (v2),
        .err_o      (err2)
    );

    bsg_gray_ptr_to_binary_rx #(
        .width_p(32),
        .sync_stages_p(3)
    ) u_dut3 (
        .clk_i      (clk),
        .reset_n_i  (reset_n),
        .gray_i     (gray),
        .clear_err_i(clear_err),
        .binary_o   (bin3),
        .delta_o    (delta3),
        .v_o        (v3),
        .err_o      (err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] to_bin(input logic [31:0] g);
        logic [31:0] r;
        r = g;
        for (int sh = 1; sh < 32; sh++) r = r ^ (g >> sh);
        return r;
    endfunction

    // hist[k] = gray input seen k+1 edges ago; a pipeline of depth s
    // presents hist[s-1] as its synchronized value.
    logic [31:0] hist [0:2];
    logic [31:0] m_bin   [2:3];
    logic [31:0] m_delta [2:3];
    logic        m_v     [2:3];
    logic        m_err   [2:3];
    logic [31:0] m_gprev [2:3];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 3; k++) hist[k] <= '0;
            for (int s = 2; s <= 3; s++) begin
                m_bin[s]   <= '0;
                m_delta[s] <= '0;
                m_v[s]     <= 1'b0;
                m_err[s]   <= 1'b0;
                m_gprev[s] <= '0;
            end
        end else begin
            hist[0] <= gray;
            hist[1] <= hist[0];
            hist[2] <= hist[1];
            for (int s = 2; s <= 3; s++) begin
                m_bin[s]   <= to_bin(hist[s-1]);
                m_delta[s] <= to_bin(hist[s-1]) - m_bin[s];
                m_v[s]     <= to_bin(hist[s-1]) != m_bin[s];
                m_gprev[s] <= hist[s-1];
                m_err[s]   <= ($countones(hist[s-1] ^ m_gprev[s]) > 1) ||
                              (m_err[s] && !clear_err);
            end
        end
    end

    task automatic test_reset();
        reset_n = 1'b0;
        clear_err = 1'b0;
        gray = 32'h0;
        #1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            gray = (c % 2 == 0) ? 32'h5 : 32'h0;
            @(posedge clk);
            #1;
            checks++;
            if ({bin2, delta2, v2, err2, bin3, delta3, v3, err3} !== '0) begin
                errors++;
                $display("FAIL reset_outs got %h/%h/%b/%b want 0", bin2, delta2, v2, err2);
            end
        end
        @(negedge clk);
        gray = 32'h0;
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (v2 !== 1'b0 || v3 !== 1'b0 || bin2 !== 32'h0) begin
                errors++;
                $display("FAIL reset_idle_v got v2=%b v3=%b bin=%h want 0", v2, v3, bin2);
            end
        end
    endtask

    task automatic test_step();
        @(negedge clk);
        gray = 32'h1;
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if (e >= 3 && e <= 5) begin
                if (bin2 !== 32'(e - 2) || delta2 !== 32'h1 || v2 !== 1'b1 || err2 !== 1'b0) begin
                    errors++;
                    $display("FAIL step_s2 e=%0d got %h/%h/%b/%b want %h/1/1/0",
                             e, bin2, delta2, v2, err2, e - 2);
                end
            end else if (v2 !== 1'b0) begin
                errors++;
                $display("FAIL step_s2_idle e=%0d got v=%b want 0", e, v2);
            end
            checks++;
            if (e >= 4) begin
                if (bin3 !== 32'(e - 3) || delta3 !== 32'h1 || v3 !== 1'b1 || err3 !== 1'b0) begin
                    errors++;
                    $display("FAIL step_s3 e=%0d got %h/%h/%b/%b want %h/1/1/0",
                             e, bin3, delta3, v3, err3, e - 3);
                end
            end else if (v3 !== 1'b0) begin
                errors++;
                $display("FAIL step_s3_idle e=%0d got v=%b want 0", e, v3);
            end
            @(negedge clk);
            if (e == 1) gray = 32'h3;
            else if (e == 2) gray = 32'h2;
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        gray = 32'h0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        gray = 32'h8000_0000;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bin2 !== 32'hFFFF_FFFF || delta2 !== 32'hFFFF_FFFF || v2 !== 1'b1) begin
            errors++;
            $display("FAIL wrap_top got %h/%h/%b want ffffffff/ffffffff/1", bin2, delta2, v2);
        end
        @(negedge clk);
        gray = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bin2 !== 32'h0 || delta2 !== 32'h1 || v2 !== 1'b1 || err2 !== 1'b0) begin
            errors++;
            $display("FAIL wrap_zero got %h/%h/%b/%b want 0/1/1/0", bin2, delta2, v2, err2);
        end
    endtask

    task automatic test_error();
        @(negedge clk);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        gray = 32'h3;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bin2 !== 32'h2 || delta2 !== 32'h2 || err2 !== 1'b1) begin
            errors++;
            $display("FAIL err_set got %h/%h/%b want 2/2/1", bin2, delta2, err2);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (err2 !== 1'b1 || v2 !== 1'b0) begin
            errors++;
            $display("FAIL err_sticky got err=%b v=%b want 1/0", err2, v2);
        end
        @(negedge clk);
        clear_err = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (err2 !== 1'b0) begin
            errors++;
            $display("FAIL err_clear got %b want 0", err2);
        end
        @(negedge clk);
        clear_err = 1'b0;
        gray = 32'h0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        clear_err = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (err2 !== 1'b1 || bin2 !== 32'h0) begin
            errors++;
            $display("FAIL err_vs_clear got err=%b bin=%h want 1/0", err2, bin2);
        end
        @(negedge clk);
        clear_err = 1'b0;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        gray = 32'h18;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bin2 !== 32'h10) begin
            errors++;
            $display("FAIL arst_pre got %h want 10", bin2);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bin2, delta2, v2, err2, bin3, delta3, v3, err3} !== '0) begin
            errors++;
            $display("FAIL arst_drop got %h/%h/%b/%b want 0", bin2, delta2, v2, err2);
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bin2 !== 32'h10 || delta2 !== 32'h10 || v2 !== 1'b1 || err2 !== m_err[2]) begin
            errors++;
            $display("FAIL arst_after got %h/%h/%b/%b want 10/10/1/%b",
                     bin2, delta2, v2, err2, m_err[2]);
        end
    endtask

    task automatic test_random();
        logic [31:0] src;
        int          r;
        src = to_bin(gray);
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            r = $urandom_range(0, 9);
            if (r < 6) src = src + 32'($urandom_range(0, 3));
            else if (r < 8) src = src + 32'h1;
            else src = $urandom;
            gray = src ^ (src >> 1);
            clear_err = ($urandom_range(0, 7) == 0);
            @(posedge clk);
            #1;
            checks++;
            if (bin2 !== m_bin[2] || delta2 !== m_delta[2] || v2 !== m_v[2] || err2 !== m_err[2]) begin
                errors++;
                $display("FAIL rand_s2 c=%0d got %h/%h/%b/%b want %h/%h/%b/%b", c,
                         bin2, delta2, v2, err2, m_bin[2], m_delta[2], m_v[2], m_err[2]);
            end
            checks++;
            if (bin3 !== m_bin[3] || delta3 !== m_delta[3] || v3 !== m_v[3] || err3 !== m_err[3]) begin
                errors++;
                $display("FAIL rand_s3 c=%0d got %h/%h/%b/%b want %h/%h/%b/%b", c,
                         bin3, delta3, v3, err3, m_bin[3], m_delta[3], m_v[3], m_err[3]);
            end
        end
        @(negedge clk);
        clear_err = 1'b0;
    endtask

    initial begin
        test_reset();
        test_step();
        test_wrap();
        test_error();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
